// File: rtl/common_pkg.sv
// Shared types and helpers for the audio mix-and-DAC path.
package common_pkg;

    typedef logic signed [15:0] audio_sample_t;

    typedef enum logic [1:0] {
        IDLE,
        SUM,
        SAT,
        FADE
    } mixer_state_t;

    function automatic int unsigned AUDIO_UNITY_GAIN(input int unsigned gain_width);
        return 32'd1 << (gain_width - 1);
    endfunction

endpackage

// File: rtl/audio_ds_dac.sv
// Delta-sigma bitstream generator for the mixed sample.
// First order by default; AUDIO_MIXER_DS2_EN selects a second-order error-feedback loop.
module audio_ds_dac (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic signed [15:0] dac_i,
    output logic               dac_o
);

`ifdef AUDIO_MIXER_DS2_EN
    localparam logic signed [21:0] LIM_HI = 22'sd524287;
    localparam logic signed [21:0] LIM_LO = -22'sd524288;

    logic signed [19:0] int1;
    logic signed [19:0] int2;
    logic signed [21:0] fb;
    logic signed [21:0] sum1;
    logic signed [21:0] sum2;

    // Clamp keeps a full-scale input from wrapping the integrators.
    function automatic logic signed [19:0] clip20(input logic signed [21:0] v);
        if (v > LIM_HI) return 20'sh7ffff;
        if (v < LIM_LO) return -20'sh80000;
        return v[19:0];
    endfunction

    always_comb begin
        fb   = dac_o ? 22'sd32768 : -22'sd32768;
        sum1 = 22'(int1) + 22'(dac_i) - fb;
        sum2 = 22'(int2) + 22'(int1) - fb;
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            int1  <= '0;
            int2  <= '0;
            dac_o <= 1'b0;
        end else begin
            int1  <= clip20(sum1);
            int2  <= clip20(sum2);
            dac_o <= (clip20(sum2) > 20'sd0);
        end
    end
`else
    logic [16:0] acc17;
    logic [15:0] u;

    assign u = $unsigned(dac_i) + 16'h8000;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) acc17 <= '0;
        else            acc17 <= {1'b0, acc17[15:0]} + {1'b0, u};
    end

    assign dac_o = acc17[16];
`endif

endmodule

// File: rtl/audio_mixer_dac.sv
// Time-multiplexed gain mixer with saturation, fade ramp and delta-sigma output.
// Define AUDIO_MIXER_DS2_EN for the second-order modulator in audio_ds_dac.
module audio_mixer_dac
    import common_pkg::*;
#(
    parameter int unsigned CHANNELS     = 4,
    parameter int unsigned SAMPLE_WIDTH = 16,
    parameter int unsigned GAIN_WIDTH   = 4,
    parameter int unsigned FADE_WIDTH   = 6
) (
    input  logic                             clk_i,
    input  logic                             reset_n_i,
    input  logic                             sample_en_i,
    input  logic [CHANNELS*SAMPLE_WIDTH-1:0] ch_data_i,
    input  logic                             gain_wr_i,
    input  logic [$clog2(CHANNELS)-1:0]      gain_sel_i,
    input  logic [GAIN_WIDTH-1:0]            gain_data_i,
    input  logic                             mute_i,
    output logic signed [15:0]               mix_o,
    output logic                             mix_valid_o,
    output logic                             busy_o,
    output logic                             clip_o,
    output logic                             overrun_o,
    output logic                             dac_o
);

    localparam int unsigned SEL_W  = $clog2(CHANNELS);
    localparam int unsigned PROD_W = SAMPLE_WIDTH + GAIN_WIDTH + 1;
    localparam int unsigned ACC_W  = PROD_W + SEL_W;
    localparam int unsigned FULL_W = 17 + FADE_WIDTH;
    localparam logic [FADE_WIDTH-1:0] LEVEL_MAX = '1;
    localparam logic [GAIN_WIDTH-1:0] UNITY = GAIN_WIDTH'(AUDIO_UNITY_GAIN(GAIN_WIDTH));
    localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(32767);
    localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(-32768);

    logic [GAIN_WIDTH-1:0]          gain    [CHANNELS];
    logic [GAIN_WIDTH-1:0]          gain_sh [CHANNELS];
    logic signed [SAMPLE_WIDTH-1:0] data_sh [CHANNELS];
    logic signed [ACC_W-1:0]        acc;
    logic [SEL_W-1:0]               ch_idx;
    logic [FADE_WIDTH-1:0]          level;
    mixer_state_t                   state;

    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  scaled;
    logic signed [FULL_W-1:0] faded_full;
    audio_sample_t            sat_val;
    audio_sample_t            faded;
    logic                     clamped;

    always_comb begin
        prod       = PROD_W'(data_sh[ch_idx]) * PROD_W'($signed({1'b0, gain_sh[ch_idx]}));
        scaled     = acc >>> (GAIN_WIDTH - 1);
        clamped    = 1'b0;
        sat_val    = scaled[15:0];
        if (scaled > SAT_HI) begin
            sat_val = 16'sh7fff;
            clamped = 1'b1;
        end else if (scaled < SAT_LO) begin
            sat_val = -16'sh8000;
            clamped = 1'b1;
        end
        faded_full = FULL_W'(sat_val) * FULL_W'($signed({1'b0, level}));
        // Full level bypasses the multiply so unity passes the sample bit-exact.
        faded      = (level == LEVEL_MAX) ? sat_val : audio_sample_t'(faded_full >>> FADE_WIDTH);
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int unsigned k = 0; k < CHANNELS; k++) gain[k] <= UNITY;
        end else if (gain_wr_i && (32'(gain_sel_i) < CHANNELS)) begin
            gain[gain_sel_i] <= gain_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state       <= IDLE;
            acc         <= '0;
            ch_idx      <= '0;
            level       <= '0;
            mix_o       <= '0;
            mix_valid_o <= 1'b0;
            busy_o      <= 1'b0;
            clip_o      <= 1'b0;
            overrun_o   <= 1'b0;
            for (int unsigned k = 0; k < CHANNELS; k++) begin
                data_sh[k] <= '0;
                gain_sh[k] <= UNITY;
            end
        end else begin
            mix_valid_o <= 1'b0;
            clip_o      <= 1'b0;
            if (sample_en_i && busy_o) overrun_o <= 1'b1;
            case (state)
                IDLE: if (sample_en_i) begin
                    for (int unsigned k = 0; k < CHANNELS; k++) begin
                        data_sh[k] <= ch_data_i[k*SAMPLE_WIDTH +: SAMPLE_WIDTH];
                        gain_sh[k] <= gain[k];
                    end
                    acc    <= '0;
                    ch_idx <= '0;
                    busy_o <= 1'b1;
                    state  <= SUM;
                end
                SUM: begin
                    acc <= acc + ACC_W'(prod);
                    if (ch_idx == SEL_W'(CHANNELS - 1)) state  <= SAT;
                    else                                ch_idx <= ch_idx + SEL_W'(1);
                end
                // Result is registered here so mix_valid_o is visible during FADE.
                SAT: begin
                    mix_o       <= faded;
                    clip_o      <= clamped;
                    mix_valid_o <= 1'b1;
                    state       <= FADE;
                end
                FADE: begin
                    if (mute_i) begin
                        if (level != '0) level <= level - 1'b1;
                    end else if (level != LEVEL_MAX) begin
                        level <= level + 1'b1;
                    end
                    busy_o <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    audio_ds_dac u_dac (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .dac_i     (mix_o),
        .dac_o     (dac_o)
    );

endmodule

// File: tb/tb_audio_mixer_dac.sv
// Self-checking bench for audio_mixer_dac against a behavioural mix/fade model.
module tb_audio_mixer_dac;

    localparam int C    = 4;
    localparam int SW   = 16;
    localparam int GW   = 4;
    localparam int FW   = 6;
    localparam int LMAX = (1 << FW) - 1;
    localparam int UNIT = 1 << (GW - 1);
    localparam int NDAC = 8192;

    logic                clk = 1'b0;
    logic                rst_n = 1'b1;
    logic                sample_en = 1'b0;
    logic [C*SW-1:0]     ch_data = '0;
    logic                gain_wr = 1'b0;
    logic [1:0]          gain_sel = '0;
    logic [GW-1:0]       gain_data = '0;
    logic                mute = 1'b0;
    logic signed [15:0]  mix;
    logic                mix_valid, busy, clip, overrun, dac;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    audio_mixer_dac #(.CHANNELS(C), .SAMPLE_WIDTH(SW), .GAIN_WIDTH(GW), .FADE_WIDTH(FW)) dut (
        .clk_i(clk), .reset_n_i(rst_n), .sample_en_i(sample_en), .ch_data_i(ch_data),
        .gain_wr_i(gain_wr), .gain_sel_i(gain_sel), .gain_data_i(gain_data), .mute_i(mute),
        .mix_o(mix), .mix_valid_o(mix_valid), .busy_o(busy), .clip_o(clip),
        .overrun_o(overrun), .dac_o(dac)
    );

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_range(input string name, input longint act, input longint lo, input longint hi);
        n_checks++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    // Behavioural model: a countdown of remaining busy cycles plus plain integer arithmetic.
    int m_rem, m_level;
    int m_gain [C];
    int m_sh_data [C];
    int m_sh_gain [C];
    int exp_mix;
    bit exp_valid, exp_busy, exp_clip, exp_ovr;

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_rem = 0; m_level = 0; exp_mix = 0;
            exp_valid = 0; exp_busy = 0; exp_clip = 0; exp_ovr = 0;
            for (int k = 0; k < C; k++) m_gain[k] = UNIT;
        end else begin
            bit busy_now;
            if (m_rem == 1) begin
                if (mute && m_level > 0) m_level--;
                else if (!mute && m_level < LMAX) m_level++;
            end
            busy_now = (m_rem > 0);
            if (busy_now) m_rem--;
            exp_valid = 0;
            exp_clip  = 0;
            if (sample_en) begin
                if (busy_now) exp_ovr = 1;
                else begin
                    for (int k = 0; k < C; k++) begin
                        m_sh_data[k] = int'($signed(ch_data[k*SW +: SW]));
                        m_sh_gain[k] = m_gain[k];
                    end
                    m_rem = C + 2;
                end
            end
            if (gain_wr) m_gain[gain_sel] = int'(gain_data);
            exp_busy = (m_rem > 0);
            if (m_rem == 1) begin
                int sum, sc, sat;
                sum = 0;
                for (int k = 0; k < C; k++) sum += m_sh_data[k] * m_sh_gain[k];
                sc = sum >>> (GW - 1);
                sat = sc;
                if (sc > 32767) begin sat = 32767; exp_clip = 1; end
                else if (sc < -32768) begin sat = -32768; exp_clip = 1; end
                exp_mix   = (m_level == LMAX) ? sat : ((sat * m_level) >>> FW);
                exp_valid = 1;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        check("mix_o", mix, exp_mix);
        check("mix_valid_o", mix_valid, exp_valid);
        check("busy_o", busy, exp_busy);
        check("clip_o", clip, exp_clip);
        check("overrun_o", overrun, exp_ovr);
    end

    task automatic do_mix(input logic [C*SW-1:0] data, input bit mid_wr, input logic [1:0] wsel,
                          input logic [GW-1:0] wval, output int mixv, output bit clp, output int lat);
        sample_en = 1'b1;
        ch_data   = data;
        @(negedge clk);
        sample_en = 1'b0;
        if (mid_wr) begin gain_wr = 1'b1; gain_sel = wsel; gain_data = wval; end
        lat = 1;
        while (!mix_valid && lat < 20) begin
            @(negedge clk);
            gain_wr = 1'b0;
            lat++;
        end
        gain_wr = 1'b0;
        check("mix_valid_within_bound", mix_valid, 1);
        mixv = mix;
        clp  = clip;
        @(negedge clk);
    endtask

    task automatic write_gain(input logic [1:0] sel, input logic [GW-1:0] val);
        gain_wr = 1'b1; gain_sel = sel; gain_data = val;
        @(negedge clk);
        gain_wr = 1'b0;
    endtask

    int mixv, lat, ones, tol;
    bit clp;
    logic signed [15:0] v;
    logic signed [15:0] dac_vals [3];

    initial begin
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_mix_o", mix, 0);
        check("reset_busy_o", busy, 0);
        check("reset_dac_o", dac, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Fade-in ramp from level 0 to full on a single channel.
        for (int i = 0; i < 64; i++) begin
            do_mix({48'd0, 16'd1000}, 1'b0, 2'd0, '0, mixv, clp, lat);
            check("latency", lat, C + 2);
            if (i == 0)  check("ramp_first", mixv, 0);
            if (i == 32) check("ramp_mid", mixv, 500);
            if (i == 63) check("ramp_full", mixv, 1000);
            repeat (64 - (C + 3)) @(negedge clk);
        end

        v = 16'sd20000;
        do_mix({v, v, v, v}, 1'b0, 2'd0, '0, mixv, clp, lat);
        check("sat_pos_mix", mixv, 32767);
        check("sat_pos_clip", clp, 1);
        v = -16'sd20000;
        do_mix({v, v, v, v}, 1'b0, 2'd0, '0, mixv, clp, lat);
        check("sat_neg_mix", mixv, -32768);
        check("sat_neg_clip", clp, 1);

        write_gain(2'd1, 4'd4);
        write_gain(2'd2, 4'd0);
        do_mix({16'd0, 16'd8000, 16'd8000, 16'd0}, 1'b0, 2'd0, '0, mixv, clp, lat);
        check("gain_half_zero", mixv, 4000);
        do_mix({16'd0, 16'd0, 16'd8000, 16'd0}, 1'b1, 2'd1, 4'd8, mixv, clp, lat);
        check("gain_write_mid_mix", mixv, 4000);
        do_mix({16'd0, 16'd0, 16'd8000, 16'd0}, 1'b0, 2'd0, '0, mixv, clp, lat);
        check("gain_write_next_mix", mixv, 8000);

        // Randomized mixes without overruns.
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 3) == 0) mute = $urandom_range(0, 1) == 1;
            if ($urandom_range(0, 2) == 0) write_gain(2'($urandom_range(0, 3)), GW'($urandom));
            do_mix({$urandom, $urandom}, $urandom_range(0, 3) == 0, 2'($urandom_range(0, 3)),
                   GW'($urandom), mixv, clp, lat);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        check("overrun_before", overrun, 0);
        sample_en = 1'b1; ch_data = {48'd0, 16'd100};
        @(negedge clk);
        sample_en = 1'b0;
        @(negedge clk);
        sample_en = 1'b1; ch_data = {48'd0, 16'd7777};
        @(negedge clk);
        sample_en = 1'b0;
        check("overrun_set", overrun, 1);
        for (int i = 0; i < 20 && busy; i++) @(negedge clk);
        check("busy_drops", busy, 0);
        for (int i = 0; i < 3; i++) do_mix({$urandom, $urandom}, 1'b0, 2'd0, '0, mixv, clp, lat);
        check("overrun_sticky", overrun, 1);

        // Raw random traffic, overruns allowed.
        for (int i = 0; i < 2000; i++) begin
            sample_en = $urandom_range(0, 7) == 0;
            gain_wr   = $urandom_range(0, 7) == 0;
            gain_sel  = 2'($urandom);
            gain_data = GW'($urandom);
            ch_data   = {$urandom, $urandom};
            if ($urandom_range(0, 63) == 0) mute = ~mute;
            @(negedge clk);
        end
        sample_en = 1'b0; gain_wr = 1'b0; mute = 1'b0;
        repeat (C + 4) @(negedge clk);

        for (int k = 0; k < C; k++) write_gain(2'(k), 4'd8);
        for (int i = 0; i < 64; i++) do_mix('0, 1'b0, 2'd0, '0, mixv, clp, lat);
`ifdef AUDIO_MIXER_DS2_EN
        tol = 2;
`else
        tol = 1;
`endif
        dac_vals[0] = 16'sd0; dac_vals[1] = 16'sd16384; dac_vals[2] = -16'sd32768;
        for (int j = 0; j < 3; j++) begin
            int expd;
            v = dac_vals[j];
            do_mix({48'd0, v}, 1'b0, 2'd0, '0, mixv, clp, lat);
            check("dac_hold_mix", mixv, v);
            repeat (16) @(negedge clk);
            ones = 0;
            for (int n = 0; n < NDAC; n++) begin
                if (dac) ones++;
                @(negedge clk);
            end
            expd = int'((longint'(NDAC) * (longint'(v) + 32768)) / 65536);
            check_range("dac_ones", ones, expd - tol, expd + tol);
        end

        // Asynchronous reset mid-SUM.
        sample_en = 1'b1; ch_data = {16'd5, 16'd5, 16'd5, 16'd5};
        @(negedge clk);
        sample_en = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        check("async_mix_o", mix, 0);
        check("async_valid", mix_valid, 0);
        check("async_busy", busy, 0);
        check("async_clip", clip, 0);
        check("async_overrun", overrun, 0);
        check("async_dac", dac, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_mix({48'd0, 16'd1000}, 1'b0, 2'd0, '0, mixv, clp, lat);
        check("post_reset_level0", mixv, 0);
        do_mix({48'd0, 16'd1000}, 1'b0, 2'd0, '0, mixv, clp, lat);
        check("post_reset_level1", mixv, 15);
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
